// File: rtl/bcd2bin_pkg.sv
// Shared definitions for the BCD to binary converter.
//   W_DEF     : default binary result width (also the shift count)
//   DIGIT_MAX : largest legal BCD digit value
//   state_t   : converter FSM states
package bcd2bin_pkg;

    localparam int         W_DEF     = 9;
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // True when a 4-bit value is not a legal BCD digit
    function automatic logic bad_digit(input logic [3:0] d);
        return d > DIGIT_MAX;
    endfunction

endpackage

// File: rtl/bcd2bin_sub_3_digit.sv
// Reverse double-dabble correction cell: one BCD digit after a right shift.
// A digit that is >= 8 has received a bit worth 10 from the digit above, where
// it should be worth 5. Subtracting 3 puts it back into BCD form.
//   din  : shifted digit
//   dout : corrected digit (din >= 8 ? din - 3 : din), 4-bit wrap, no borrow
module sub_3_digit (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din[3]) dout = din - 4'd3;
    end

endmodule

// File: rtl/bcd2bin.sv
// Sequential 3-digit BCD to W-bit binary converter (reverse double dabble).
// One request at a time through a start/busy/done handshake.
//   clk   : system clock, rising edge
//   rst   : synchronous reset, active-high
//   start : request pulse, sampled only while idle
//   H/T/O : hundreds / tens / ones BCD digits
//   busy  : conversion in progress
//   done  : one-cycle pulse when A and err are valid
//   err   : last request had an illegal digit or did not fit in W bits
//   A     : binary result (0 whenever err is set)
module bcd2bin
    import bcd2bin_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   H,
    input  logic [3:0]   T,
    input  logic [3:0]   O,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] A
);

    state_t          state, state_nx;
    logic [11:0]     bcd, bcd_nx;
    logic [W-1:0]    bin, bin_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            done_nx, err_nx;
    logic [W-1:0]    a_nx;

    // One shift step: the lsb of the BCD register falls into the top of bin
    logic [11+W:0]   sh;
    logic [11:0]     bcd_sh, bcd_cor;
    logic [W-1:0]    bin_sh;

    assign sh     = {bcd, bin} >> 1;
    assign bcd_sh = sh[11+W:W];
    assign bin_sh = sh[W-1:0];

    // All three digits are corrected in parallel; no borrow between digits
    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dig
            sub_3_digit u_sub (
                .din  (bcd_sh[4*g +: 4]),
                .dout (bcd_cor[4*g +: 4])
            );
        end
    endgenerate

    assign busy = (state == SHIFT);

    always_comb begin
        state_nx = state;
        bcd_nx   = bcd;
        bin_nx   = bin;
        cnt_nx   = cnt;
        done_nx  = 1'b0;
        err_nx   = err;
        a_nx     = A;
        case (state)
            IDLE: begin
                if (start) begin
                    bcd_nx = {H, T, O};
                    bin_nx = '0;
                    cnt_nx = '0;
                    err_nx = 1'b0;
                    if (bad_digit(H) || bad_digit(T) || bad_digit(O)) begin
                        // Rejected immediately; never enters SHIFT
                        done_nx = 1'b1;
                        err_nx  = 1'b1;
                        a_nx    = '0;
                    end else begin
                        state_nx = SHIFT;
                    end
                end
            end
            SHIFT: begin
                bcd_nx = bcd_cor;
                bin_nx = bin_sh;
                cnt_nx = cnt + 1'b1;
                if (cnt == CW'(W - 1)) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                    // Anything left in the BCD register is value >> W: overflow
                    if (bcd_cor != 12'd0) begin
                        err_nx = 1'b1;
                        a_nx   = '0;
                    end else begin
                        a_nx   = bin_sh;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            bcd   <= '0;
            bin   <= '0;
            cnt   <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
            A     <= '0;
        end else begin
            state <= state_nx;
            bcd   <= bcd_nx;
            bin   <= bin_nx;
            cnt   <= cnt_nx;
            done  <= done_nx;
            err   <= err_nx;
            A     <= a_nx;
        end
    end

endmodule

// File: tb/tb_bcd2bin.sv
// Scoreboard bench for bcd2bin: stimulus pushes expected results, a monitor
// pops and checks result, error flag, done cycle and busy duration.
module tb_bcd2bin;

    localparam int W = 9;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   H, T, O;
    logic         busy, done, err;
    logic [W-1:0] A;

    bcd2bin #(.W(W), .CW(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .H     (H),
        .T     (T),
        .O     (O),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .A     (A)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic         e;
        int           cyc;
        int           bsy;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   bsy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (rst) begin
                bsy_cnt = 0;
            end else begin
                if (busy) bsy_cnt++;
                if (done) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
                    end else begin
                        x = q.pop_front();
                        chk("result_A", int'(A), int'(x.a));
                        chk("result_err", int'(err), int'(x.e));
                        chk("done_cycle", cyc, x.cyc);
                        chk("busy_cycles", bsy_cnt, x.bsy);
                    end
                    bsy_cnt = 0;
                end
            end
        end
    end

    task automatic wait_empty();
        int n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    // Issue a single request; expected values are hand-computed by the caller
    task automatic convert(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                           input int ea, input logic ee, input logic bad);
        exp_t x;
        @(negedge clk);
        H = h; T = t; O = o; start = 1'b1;
        x.a   = W'(ea);
        x.e   = ee;
        x.cyc = cyc + (bad ? 1 : W + 1);
        x.bsy = bad ? 0 : W;
        q.push_back(x);
        @(negedge clk);
        start = 1'b0;
        wait_empty();
    endtask

    initial begin
        exp_t x;
        rst = 1'b1; start = 1'b0; H = '0; T = '0; O = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_A", int'(A), 0);
        rst = 1'b0;

        convert(4'd5, 4'd1, 4'd1, 511, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("hold_A", int'(A), 511);
        chk("hold_done", int'(done), 0);
        convert(4'd0, 4'd0, 4'd0, 0,   1'b0, 1'b0);
        convert(4'd2, 4'd5, 4'd5, 255, 1'b0, 1'b0);
        convert(4'd1, 4'd2, 4'd8, 128, 1'b0, 1'b0);
        convert(4'd9, 4'd9, 4'd9, 0,   1'b1, 1'b0);
        convert(4'd5, 4'd1, 4'd2, 0,   1'b1, 1'b0);
        convert(4'd0, 4'd0, 4'd0, 0,   1'b0, 1'b0);
        convert(4'd0, 4'hA, 4'd0, 0,   1'b1, 1'b1);
        chk("invalid_busy", int'(busy), 0);
        convert(4'd0, 4'd0, 4'hF, 0,   1'b1, 1'b1);

        // start held high: 123 accepted once, then 45 right after its done
        @(negedge clk);
        H = 4'd1; T = 4'd2; O = 4'd3; start = 1'b1;
        x.a = 9'd123; x.e = 1'b0; x.cyc = cyc + 10; x.bsy = 9; q.push_back(x);
        x.a = 9'd45;  x.e = 1'b0; x.cyc = cyc + 20; x.bsy = 9; q.push_back(x);
        @(negedge clk);
        H = 4'd0; T = 4'd4; O = 4'd5;
        repeat (10) @(negedge clk);
        start = 1'b0;
        wait_empty();

        // Reset mid-conversion of 300: no done, outputs cleared
        @(negedge clk);
        H = 4'd3; T = 4'd0; O = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_err", int'(err), 0);
        chk("abort_A", int'(A), 0);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("abort_idle_busy", int'(busy), 0);
        convert(4'd3, 4'd0, 4'd0, 300, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd2bin.md
Name: bcd2bin

Overview:
Sequential 3-digit BCD to 9-bit binary converter. It is the inverse of the combinational bin2bcd path and uses the reverse double-dabble algorithm: shift right, then subtract 3 from each digit that is >= 8. It takes one conversion request through a start/busy/done handshake and flags invalid digits and out-of-range values. It sits between the keypad/BCD entry logic and the binary datapath.

Parameters:
W, 9, binary result width; also equals the number of shift iterations
CW, 4, iteration counter width; must satisfy 2^CW > W

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  request pulse; sampled only when busy=0
H  in  4  hundreds digit
T  in  4  tens digit
O  in  4  ones digit
busy  out  1  conversion in progress
done  out  1  one-cycle pulse; A and err are valid while done=1 and hold until the next accepted start
err  out  1  invalid digit or overflow for the last conversion
A  out  W  binary result

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state IDLE. busy=0, done=0, err=0, A=0, internal registers cleared.
- Reset mid-operation: the conversion is aborted with no done pulse. The next cycle is IDLE with all outputs at their reset values.
- Internal registers: bcd[11:0], bin[W-1:0], cnt[CW-1:0].
- States: IDLE, SHIFT.
- IDLE, start=1 at edge k:
  - Latch bcd={H,T,O}, set bin=0, cnt=0. Clear err; A holds its previous value until the result is written.
  - If any digit > 9: stay IDLE, set done=1, err=1, A=0. Latency is 1 clock and busy never rises.
  - Otherwise: go to SHIFT, busy=1.
- SHIFT, each edge:
  - {bcd,bin} <= {bcd,bin}>>1, so bcd[0] enters bin[W-1].
  - Then, for each 4-bit digit of the shifted bcd: if digit >= 8, subtract 3 (mod 16). All three digits are corrected in parallel within the same cycle.
  - cnt <= cnt+1.
- Final iteration (cnt==W-1, edge k+W):
  - A <= next bin, done=1, busy=0, state IDLE.
  - err=1 if the next bcd != 0 (value > 2^W-1, e.g. 512..999 for W=9); in that case A=0.
  - Valid conversion latency: done is high in the cycle after edge k+W, i.e. W clocks after start was sampled.
- done is high for exactly one cycle per accepted start.
- start while busy=1: ignored, no effect on state or outputs.
- start in the same cycle as done=1: accepted, since state is already IDLE. Back-to-back throughput is one result per W+1 clocks.
- Arithmetic: digit correction is 4-bit unsigned subtraction. No carries between digits.

Decomposition:
- Shared package: constant W_DEF=9, state enum {IDLE,SHIFT}, and digit max constant 9 used by the validity check.
- One natural sub-module, sub_3_digit: a 4-bit combinational cell, output = in>=8 ? in-3 : in.
  - Instantiated 3 times on the shifted bcd, one per digit.
  - It mirrors the add-3 cell of the forward converter.
- Validity check and FSM stay in bcd2bin.

Test Plan:
- H=5,T=1,O=1, start 1 cycle -> busy=1 for 9 cycles; done=1 in the cycle after edge k+9; A=511, err=0.
- H=0,T=0,O=0 -> A=0, err=0, same 9-cycle latency. H=2,T=5,O=5 -> A=255. H=1,T=2,O=8 -> A=128.
- H=9,T=9,O=9 -> done after 9 cycles, err=1, A=0. H=5,T=1,O=2 -> err=1 (512 overflow).
- T=4'hA (H=0,O=0) -> done=1 and err=1 in the cycle after start; busy stays 0; A=0.
- start held high continuously with inputs 123 then 45 -> each accepted exactly once. A=123, then one cycle after that done A=45 conversion starts and completes; done pulses are 10 cycles apart.
- Assert rst at cycle 4 of a conversion of 300 -> no done pulse; outputs 0 next cycle. A following start with 300 -> A=300.
